// File: rtl/memory_access_arbiter.sv
// Arbiter sharing the single-port RAM between instruction fetch and data access.
// Fixed-latency access sequencing with four-phase level completion per port.
module memory_access_arbiter #(
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_req,
   input  logic              d_rw,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              i_moc,
   output logic              d_moc,
   output logic [31:0]       rdata,
   output logic              d_err,
   output logic [1:0]        grant
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_I_WAIT,
      S_D_WAIT,
      S_I_ACK,
      S_D_ACK
   } state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              last_d_q, last_d_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              rw_q, rw_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              derr_q, derr_d;

   logic              d_mis;
   logic              take_d;
   logic              in_wait;
   logic              d_write;

   // Misalignment of the requested data access (reserved size acts as word)
   always_comb begin
      d_mis = 1'b0;
      unique case (1'b1)
         (d_size == 2'b00): d_mis = 1'b0;
         (d_size == 2'b01): d_mis = d_addr[0];
         default:           d_mis = |d_addr[1:0];
      endcase
   end

   // Round-robin: data wins in IDLE unless it was also served last while fetch waits
   assign take_d = d_req && (!i_req || !last_d_q);

   // Next-state and latched access fields
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d_d = last_d_q;
      addr_d   = addr_q;
      size_d   = size_q;
      rw_d     = rw_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      derr_d   = derr_q;
      unique case (state_q)
         S_IDLE: begin
            if (take_d) begin
               last_d_d = 1'b1;
               derr_d   = d_mis;
               if (d_mis) begin
                  state_d = S_D_ACK;
               end else begin
                  state_d = S_D_WAIT;
                  cnt_d   = WAIT_LD;
                  addr_d  = d_addr;
                  size_d  = d_size;
                  rw_d    = d_rw;
                  wdata_d = d_wdata;
               end
            end else if (i_req) begin
               state_d  = S_I_WAIT;
               cnt_d    = WAIT_LD;
               last_d_d = 1'b0;
               addr_d   = {i_addr[ADDR_W-1:2], 2'b00};
               size_d   = 2'b10;
               rw_d     = 1'b1;
               wdata_d  = '0;
            end
         end
         S_I_WAIT, S_D_WAIT: begin
            if (cnt_q == 4'd0) begin
               if (rw_q) begin
                  rdata_d = mem_rdata;
               end
               state_d = (state_q == S_I_WAIT) ? S_I_ACK : S_D_ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_I_ACK: begin
            if (!i_req) begin
               state_d = S_IDLE;
            end
         end
         S_D_ACK: begin
            if (!d_req) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and field registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         last_d_q <= 1'b0;
         addr_q   <= '0;
         size_q   <= 2'b00;
         rw_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         derr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_d_q <= last_d_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         rw_q     <= rw_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         derr_q   <= derr_d;
      end
   end

   assign in_wait = (state_q == S_I_WAIT) || (state_q == S_D_WAIT);
   assign d_write = (state_q == S_D_WAIT) && !rw_q;

   // Outputs decoded from state and latched fields only
   always_comb begin
      mem_en    = in_wait;
      mem_we    = d_write && (cnt_q == 4'd0);
      mem_size  = in_wait ? size_q : 2'b00;
      mem_addr  = in_wait ? addr_q : '0;
      mem_wdata = d_write ? wdata_q : 32'd0;
      i_moc     = (state_q == S_I_ACK);
      d_moc     = (state_q == S_D_ACK);
      grant     = {state_q == S_D_WAIT, state_q == S_I_WAIT};
      rdata     = rdata_q;
      d_err     = derr_q;
   end

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed bench for memory_access_arbiter.
// Second instance uses WAIT_CYCLES=3 on the same stimulus.
module tb_memory_access_arbiter;

   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          d_req;
   logic          d_rw;
   logic [1:0]    d_size;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic [31:0]   mem_rdata;

   logic          mem_en, mem_we, i_moc, d_moc, d_err;
   logic [1:0]    mem_size, grant;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, rdata;

   logic          mem_en3, mem_we3, i_moc3, d_moc3, d_err3;
   logic [1:0]    mem_size3, grant3;
   logic [AW-1:0] mem_addr3;
   logic [31:0]   mem_wdata3, rdata3;

   int checks   = 0;
   int failures = 0;
   int we_cnt   = 0;
   int we_base;

   memory_access_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(1)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_rw(d_rw), .d_size(d_size),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .mem_rdata(mem_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .i_moc(i_moc), .d_moc(d_moc), .rdata(rdata),
      .d_err(d_err), .grant(grant)
   );

   memory_access_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_rw(d_rw), .d_size(d_size),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .mem_rdata(mem_rdata),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_size(mem_size3),
      .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
      .i_moc(i_moc3), .d_moc(d_moc3), .rdata(rdata3),
      .d_err(d_err3), .grant(grant3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_req = 1'b0;
      d_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Wait for a grant, check its owner, then finish that transaction
   task automatic serve(input string tag, input logic [1:0] exp_g);
      int n;
      n = 0;
      while (grant == 2'b00 && n < 10) begin
         tick();
         n++;
      end
      chk(tag, 32'(grant), 32'(exp_g));
      n = 0;
      while (!(i_moc || d_moc) && n < 10) begin
         tick();
         n++;
      end
      chk({tag, "_moc"}, {30'd0, i_moc, d_moc},
          (exp_g == 2'b10) ? 32'd1 : 32'd2);
      if (d_moc) d_req = 1'b0;
      if (i_moc) i_req = 1'b0;
      tick();
   endtask

   initial begin
      i_addr    = '0;
      d_rw      = 1'b1;
      d_size    = 2'b10;
      d_addr    = '0;
      d_wdata   = '0;
      mem_rdata = '0;
      do_reset();

      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_en", 32'(mem_en), 32'd0);
      chk("rst_moc", {30'd0, i_moc, d_moc}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_derr", 32'(d_err), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);

      // single fetch
      i_req     = 1'b1;
      i_addr    = 9'h004;
      mem_rdata = 32'h8C22_0000;
      tick();
      chk("f_grant1", 32'(grant), 32'd1);
      chk("f_addr", 32'(mem_addr), 32'h004);
      chk("f_size", 32'(mem_size), 32'd2);
      chk("f_moc1", 32'(i_moc), 32'd0);
      tick();
      chk("f_grant2", 32'(grant), 32'd1);
      chk("f_moc2", 32'(i_moc), 32'd0);
      tick();
      chk("f_moc3", 32'(i_moc), 32'd1);
      chk("f_rdata", rdata, 32'h8C22_0000);
      chk("f_en3", 32'(mem_en), 32'd0);
      i_req = 1'b0;
      tick();
      chk("f_drop_moc", 32'(i_moc), 32'd0);
      chk("f_drop_grant", 32'(grant), 32'd0);

      // word store
      we_base = we_cnt;
      d_req   = 1'b1;
      d_rw    = 1'b0;
      d_size  = 2'b10;
      d_addr  = 9'h010;
      d_wdata = 32'hDEAD_BEEF;
      tick();
      chk("s_grant", 32'(grant), 32'd2);
      chk("s_we1", 32'(mem_we), 32'd0);
      d_addr  = 9'h0F0;
      d_wdata = 32'h0;
      tick();
      chk("s_we2", 32'(mem_we), 32'd1);
      chk("s_addr", 32'(mem_addr), 32'h010);
      chk("s_wdata", mem_wdata, 32'hDEAD_BEEF);
      tick();
      chk("s_moc", 32'(d_moc), 32'd1);
      chk("s_we3", 32'(mem_we), 32'd0);
      chk("s_derr", 32'(d_err), 32'd0);
      d_req = 1'b0;
      tick();
      chk("s_we_count", we_cnt - we_base, 32'd1);
      chk("s_drop_moc", 32'(d_moc), 32'd0);

      // tie then alternation: D, I, D, I
      do_reset();
      d_rw      = 1'b1;
      d_addr    = 9'h020;
      i_addr    = 9'h008;
      mem_rdata = 32'h1111_1111;
      i_req     = 1'b1;
      d_req     = 1'b1;
      serve("tie1_d", 2'b10);
      serve("tie1_i", 2'b01);
      i_req = 1'b1;
      d_req = 1'b1;
      serve("tie2_d", 2'b10);
      serve("tie2_i", 2'b01);

      // misaligned word read, then aligned halfword clears d_err
      d_req  = 1'b1;
      d_rw   = 1'b1;
      d_size = 2'b10;
      d_addr = 9'h013;
      tick();
      chk("mis_moc", 32'(d_moc), 32'd1);
      chk("mis_err", 32'(d_err), 32'd1);
      chk("mis_en", 32'(mem_en), 32'd0);
      d_req = 1'b0;
      tick();
      chk("mis_err_hold", 32'(d_err), 32'd1);
      d_req  = 1'b1;
      d_size = 2'b01;
      d_addr = 9'h012;
      tick();
      chk("hw_err_clr", 32'(d_err), 32'd0);
      chk("hw_en", 32'(mem_en), 32'd1);
      chk("hw_size", 32'(mem_size), 32'd1);
      tick();
      tick();
      chk("hw_moc", 32'(d_moc), 32'd1);
      d_req = 1'b0;
      tick();

      // reset during first WAIT cycle of a store
      we_base = we_cnt;
      d_req   = 1'b1;
      d_rw    = 1'b0;
      d_size  = 2'b10;
      d_addr  = 9'h010;
      d_wdata = 32'hDEAD_BEEF;
      tick();
      chk("rw_en", 32'(mem_en), 32'd1);
      reset = 1'b1;
      d_req = 1'b0;
      tick();
      reset = 1'b0;
      chk("rw_en0", 32'(mem_en), 32'd0);
      chk("rw_grant0", 32'(grant), 32'd0);
      chk("rw_rdata0", rdata, 32'd0);
      chk("rw_moc0", {30'd0, i_moc, d_moc}, 32'd0);
      tick();
      tick();
      chk("rw_no_we", we_cnt - we_base, 32'd0);
      i_req     = 1'b1;
      i_addr    = 9'h007;
      mem_rdata = 32'h2222_3333;
      tick();
      chk("rw_f_addr", 32'(mem_addr), 32'h004);
      chk("rw_f_grant", 32'(grant), 32'd1);
      tick();
      tick();
      chk("rw_f_moc", 32'(i_moc), 32'd1);
      chk("rw_f_rdata", rdata, 32'h2222_3333);
      i_req = 1'b0;
      tick();

      // WAIT_CYCLES=3 instance: req dropped in second WAIT cycle
      do_reset();
      d_req     = 1'b1;
      d_rw      = 1'b1;
      d_size    = 2'b10;
      d_addr    = 9'h040;
      mem_rdata = 32'hCAFE_F00D;
      tick();
      chk("w3_grant", 32'(grant3), 32'd2);
      tick();
      d_req = 1'b0;
      tick();
      tick();
      chk("w3_moc_early", 32'(d_moc3), 32'd0);
      chk("w3_en", 32'(mem_en3), 32'd1);
      tick();
      chk("w3_moc", 32'(d_moc3), 32'd1);
      chk("w3_rdata", rdata3, 32'hCAFE_F00D);
      mem_rdata = 32'h0;
      tick();
      chk("w3_moc_1cyc", 32'(d_moc3), 32'd0);
      chk("w3_rdata_hold", rdata3, 32'hCAFE_F00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
